// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline register: default widths,
// WB/M control bit positions and the payload record.
package ex_mem_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int WB_W_DEF       = 2;
    localparam int M_W_DEF        = 3;
    localparam int CNT_W_DEF      = 16;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;
    localparam int M_BRANCH    = 0;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 2;

    typedef struct packed {
        logic [WB_W_DEF-1:0]       wb;
        logic [M_W_DEF-1:0]        m;
        logic [DATA_W_DEF-1:0]     add_result;
        logic                      alu_zero;
        logic [DATA_W_DEF-1:0]     alu_result;
        logic [DATA_W_DEF-1:0]     rt_data;
        logic [REG_ADDR_W_DEF-1:0] dst_reg;
    } ex_mem_payload_t;

    localparam int PAYLOAD_W_DEF = $bits(ex_mem_payload_t);

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Two-slot skid buffer (main + skid) with registered in_ready.
// Compiled only when EX_MEM_SKID_EN is defined.
`ifdef EX_MEM_SKID_EN
module ex_mem_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v_r;
    logic         skid_v_r;
    logic         in_ready_r;
    logic [W-1:0] main_d_r;
    logic [W-1:0] skid_d_r;
    logic         main_v_s;
    logic         skid_v_s;
    logic         load_main_in_s;
    logic         load_main_skid_s;
    logic         load_skid_s;

    // Next-state for both valid bits; a parked entry always drains before new input.
    always_comb begin
        main_v_s         = main_v_r;
        skid_v_s         = skid_v_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            main_v_s = 1'b0;
            skid_v_s = 1'b0;
        end else if (!main_v_r || out_ready) begin
            if (skid_v_r) begin
                main_v_s         = 1'b1;
                skid_v_s         = 1'b0;
                load_main_skid_s = 1'b1;
            end else begin
                main_v_s       = in_valid & in_ready_r;
                load_main_in_s = in_valid & in_ready_r;
            end
        end else begin
            if (in_valid && in_ready_r) begin
                skid_v_s    = 1'b1;
                load_skid_s = 1'b1;
            end else begin
                skid_v_s = skid_v_r;
            end
        end
    end

    // Slot storage and registered ready (ready = skid slot will be empty).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_r   <= 1'b0;
            skid_v_r   <= 1'b0;
            in_ready_r <= 1'b0;
            main_d_r   <= {W{1'b0}};
            skid_d_r   <= {W{1'b0}};
        end else begin
            main_v_r   <= main_v_s;
            skid_v_r   <= skid_v_s;
            in_ready_r <= ~skid_v_s;
            if (load_main_in_s) begin
                main_d_r <= in_data;
            end else if (load_main_skid_s) begin
                main_d_r <= skid_d_r;
            end else begin
                main_d_r <= main_d_r;
            end
            if (load_skid_s) begin
                skid_d_r <= in_data;
            end else begin
                skid_d_r <= skid_d_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_v_r;
    assign out_data  = main_d_r;

endmodule
`endif

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, flush, M decode and stall counter.
// Define EX_MEM_SKID_EN for a 2-entry skid buffer with registered in_ready.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int WB_W       = WB_W_DEF,
    parameter int M_W        = M_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WB_W-1:0]       wb_i,
    input  logic [M_W-1:0]        m_i,
    input  logic [DATA_W-1:0]     add_result_i,
    input  logic                  alu_zero_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [REG_ADDR_W-1:0] dst_reg_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WB_W-1:0]       wb_o,
    output logic [DATA_W-1:0]     add_result_o,
    output logic                  alu_zero_o,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [REG_ADDR_W-1:0] dst_reg_o,
    output logic                  branch_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  pc_src_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int PW = WB_W + M_W + 3 * DATA_W + 1 + REG_ADDR_W;

    logic [PW-1:0]    in_pack_s;
    logic [PW-1:0]    out_pack_s;
    logic             valid_s;
    logic [WB_W-1:0]  wb_q_s;
    logic [M_W-1:0]   m_q_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign in_pack_s = {wb_i, m_i, add_result_i, alu_zero_i, alu_result_i, rt_data_i, dst_reg_i};
    assign {wb_q_s, m_q_s, add_result_o, alu_zero_o, alu_result_o, rt_data_o, dst_reg_o} = out_pack_s;

`ifdef EX_MEM_SKID_EN
    ex_mem_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (Clk),
        .rst       (Reset),
        .flush     (flush_i),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .in_data   (in_pack_s),
        .out_valid (valid_s),
        .out_ready (out_ready_i),
        .out_data  (out_pack_s)
    );
`else
    logic          valid_r;
    logic [PW-1:0] pack_r;

    assign in_ready_o = out_ready_i | ~valid_r;

    // Single-entry register; a flush kills the held entry and any same-cycle accept.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_r <= 1'b0;
            pack_r  <= {PW{1'b0}};
        end else if (flush_i) begin
            valid_r <= 1'b0;
        end else if (in_ready_o) begin
            valid_r <= in_valid_i;
            if (in_valid_i) begin
                pack_r <= in_pack_s;
            end else begin
                pack_r <= pack_r;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid_s    = valid_r;
    assign out_pack_s = pack_r;
`endif

    // Bubbles must never write memory, registers or redirect the PC.
    assign out_valid_o = valid_s;
    assign branch_o    = m_q_s[M_BRANCH] & valid_s;
    assign mem_read_o  = m_q_s[M_MEMREAD] & valid_s;
    assign mem_write_o = m_q_s[M_MEMWRITE] & valid_s;
    assign pc_src_o    = branch_o & alu_zero_o;

    // WB passthrough with RegWrite gated by valid.
    always_comb begin
        wb_o              = wb_q_s;
        wb_o[WB_REGWRITE] = wb_q_s[WB_REGWRITE] & valid_s;
    end

    // Saturating count of cycles where MEM holds off a valid entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (valid_s && !out_ready_i && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg (default single-entry build, CNT_W=4).
module tb_ex_mem_pipe_reg;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  wb_i;
    logic [2:0]  m_i;
    logic [31:0] add_result_i;
    logic        alu_zero_i;
    logic [31:0] alu_result_i;
    logic [31:0] rt_data_i;
    logic [4:0]  dst_reg_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [1:0]  wb_o;
    logic [31:0] add_result_o;
    logic        alu_zero_o;
    logic [31:0] alu_result_o;
    logic [31:0] rt_data_o;
    logic [4:0]  dst_reg_o;
    logic        branch_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        pc_src_o;
    logic [3:0]  stall_cnt_o;

    ex_mem_pipe_reg #(
        .DATA_W (32), .REG_ADDR_W (5), .WB_W (2), .M_W (3), .CNT_W (4)
    ) dut (
        .Clk (Clk), .Reset (Reset), .flush_i (flush_i),
        .in_valid_i (in_valid_i), .in_ready_o (in_ready_o),
        .wb_i (wb_i), .m_i (m_i), .add_result_i (add_result_i), .alu_zero_i (alu_zero_i),
        .alu_result_i (alu_result_i), .rt_data_i (rt_data_i), .dst_reg_i (dst_reg_i),
        .out_valid_o (out_valid_o), .out_ready_i (out_ready_i),
        .wb_o (wb_o), .add_result_o (add_result_o), .alu_zero_o (alu_zero_o),
        .alu_result_o (alu_result_o), .rt_data_o (rt_data_o), .dst_reg_o (dst_reg_o),
        .branch_o (branch_o), .mem_read_o (mem_read_o), .mem_write_o (mem_write_o),
        .pc_src_o (pc_src_o), .stall_cnt_o (stall_cnt_o)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] add;
        logic [31:0] rt;
        logic [4:0]  dst;
        logic [1:0]  wb;
        logic        zero;
        logic [3:0]  ctl;   // {branch, mem_read, mem_write, pc_src}
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_got;
    obs_t mon_exp;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive one EX beat at posedge+1; push the hand-computed MEM view if it should emerge.
    task automatic send(input logic fl, input logic push, input logic [1:0] wb, input logic [2:0] m,
                        input logic [31:0] add, input logic zero, input logic [31:0] alu,
                        input logic [31:0] rt, input logic [4:0] dst, input logic [3:0] exp_ctl);
        flush_i      = fl;
        in_valid_i   = 1'b1;
        wb_i         = wb;
        m_i          = m;
        add_result_i = add;
        alu_zero_i   = zero;
        alu_result_i = alu;
        rt_data_i    = rt;
        dst_reg_i    = dst;
        if (push) exp_q.push_back({alu, add, rt, dst, wb, zero, exp_ctl});
        @(posedge Clk);
        #1;
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Monitor: every transfer out is compared against the oldest expected entry.
    always @(negedge Clk) begin
        if (!Reset && out_valid_o && out_ready_i) begin
            mon_got = {alu_result_o, add_result_o, rt_data_o, dst_reg_o, wb_o, alu_zero_o,
                       branch_o, mem_read_o, mem_write_o, pc_src_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got=%h expected=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL transfer: got=%h expected=%h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        wb_i = 2'b00; m_i = 3'b000; add_result_i = 32'h0; alu_zero_i = 1'b0;
        alu_result_i = 32'h0; rt_data_i = 32'h0; dst_reg_i = 5'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_valid", out_valid_o, 1'b0);
        check("reset_cnt", stall_cnt_o, 4'h0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        idle(1);
        check("ready_after_reset", in_ready_o, 1'b1);
        check("payload_reset", alu_result_o, 32'h0);

        // Passthrough and back-to-back run
        out_ready_i = 1'b1;
        send(1'b0, 1'b1, 2'b00, 3'b100, 32'h0, 1'b0, 32'h0000_1004, 32'hdead_beef, 5'd0, 4'b0010);
        check("pt_alu", alu_result_o, 32'h0000_1004);
        check("pt_memwrite", mem_write_o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 1'b1, 2'b01, 3'b000, 32'h100 + 32'(i * 4), 1'b0, 32'h2000 + 32'(i),
                 32'(i), 5'(i + 1), 4'b0000);
            check("b2b_valid", out_valid_o, 1'b1);
        end
        idle(2);

        // Branch taken / not taken, and a load
        send(1'b0, 1'b1, 2'b00, 3'b001, 32'h40, 1'b1, 32'h0, 32'h0, 5'd0, 4'b1001);
        check("br_taken_pcsrc", pc_src_o, 1'b1);
        check("br_taken_target", add_result_o, 32'h40);
        send(1'b0, 1'b1, 2'b00, 3'b001, 32'h40, 1'b0, 32'h0, 32'h0, 5'd0, 4'b1000);
        check("br_not_taken_pcsrc", pc_src_o, 1'b0);
        send(1'b0, 1'b1, 2'b11, 3'b010, 32'h0, 1'b0, 32'h3000, 32'h0, 5'd9, 4'b0100);
        idle(2);

        // Stall for 3 cycles with a held entry
        out_ready_i = 1'b0;
        send(1'b0, 1'b1, 2'b01, 3'b000, 32'h0, 1'b0, 32'h5555_aaaa, 32'h1234, 5'd7, 4'b0000);
        idle(3);
        check("stall_cnt3", stall_cnt_o, 4'h3);
        check("stall_payload", alu_result_o, 32'h5555_aaaa);
        check("stall_valid", out_valid_o, 1'b1);
        check("stall_ready", in_ready_o, 1'b0);
        out_ready_i = 1'b1;
        idle(2);

        // Flush drops the same-cycle accept
        send(1'b1, 1'b0, 2'b01, 3'b111, 32'h80, 1'b1, 32'h0000_ffff, 32'h1, 5'd3, 4'b0000);
        check("flush_valid", out_valid_o, 1'b0);
        check("flush_memread", mem_read_o, 1'b0);
        check("flush_memwrite", mem_write_o, 1'b0);
        check("flush_pcsrc", pc_src_o, 1'b0);
        check("flush_regwrite", wb_o[0], 1'b0);
        send(1'b0, 1'b1, 2'b10, 3'b010, 32'h0, 1'b0, 32'h4000, 32'h0, 5'd4, 4'b0100);
        idle(2);

        // Asynchronous reset with a held store
        out_ready_i = 1'b0;
        send(1'b0, 1'b0, 2'b00, 3'b100, 32'h0, 1'b0, 32'h6000, 32'h77, 5'd0, 4'b0010);
        idle(1);
        check("pre_reset_valid", out_valid_o, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_valid", out_valid_o, 1'b0);
        check("async_reset_memwrite", mem_write_o, 1'b0);
        check("async_reset_cnt", stall_cnt_o, 4'h0);
        #1 Reset = 1'b0;
        idle(1);

        // Counter saturation over 20 stalled cycles
        send(1'b0, 1'b1, 2'b01, 3'b000, 32'h0, 1'b0, 32'h7000, 32'h0, 5'd5, 4'b0000);
        idle(20);
        check("sat_cnt", stall_cnt_o, 4'hF);
        out_ready_i = 1'b1;
        idle(3);
        check("sat_hold", stall_cnt_o, 4'hF);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
